// File: rtl/instr_fetch.sv
// KNIPS instruction fetch: PC sequencing, jump/branch redirect through a 16-entry
// target LUT, and opcode/operand split of the instruction returned by the ROM.
module instr_fetch #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               lut_we,
    input  logic [3:0]         lut_idx,
    input  logic [PC_W-1:0]    lut_data,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         opcode,
    output logic [3:0]         operand,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               done
);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JUMP   = 5'b11001;
    localparam logic [4:0] OP_HALT   = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [PC_W-1:0]   instr_pc_reg;
    logic [PC_W-1:0]   lut_reg [16];
    logic              redirect;

    assign instr       = imem_rdata;
    assign opcode      = imem_rdata[INSTR_W-1 -: 5];
    assign operand     = imem_rdata[3:0];
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = (state_reg == RUN);
    assign done        = (state_reg == DONE);

    // The LUT must clear on reset, so it is kept in flops rather than block RAM.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lut
            always_ff @(posedge clk) begin
                if (reset) begin
                    lut_reg[gi] <= '0;
                end else if (lut_we && (lut_idx == 4'(gi))) begin
                    lut_reg[gi] <= lut_data;
                end
            end
        end
    endgenerate

    assign redirect = (opcode == OP_JUMP) || ((opcode == OP_BRANCH) && branch_taken);

    always_comb begin
        state_next = state_reg;
        imem_addr  = instr_pc_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    imem_addr  = start_addr;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A stalled redirect is simply re-evaluated once stall drops.
                if (stall) begin
                    imem_addr = instr_pc_reg;
                end else if (redirect) begin
                    imem_addr = lut_reg[operand];
                end else begin
                    imem_addr = instr_pc_reg + 1'b1;
                end
                if (!stall && (opcode == OP_HALT)) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            instr_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            instr_pc_reg <= imem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous ROM model; each task drives
// one scenario and checks hand-computed addresses and flags.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       stall;
    logic       branch_taken;
    logic       lut_we;
    logic [3:0] lut_idx;
    logic [9:0] lut_data;
    logic [9:0] imem_addr;
    logic [8:0] imem_rdata;
    logic [8:0] instr;
    logic [4:0] opcode;
    logic [3:0] operand;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       done;

    logic [8:0] rom [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    instr_fetch dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .lut_we(lut_we),
        .lut_idx(lut_idx), .lut_data(lut_data), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .operand(operand), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .done(done)
    );

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
        lut_we = 1'b1; lut_idx = idx; lut_data = data;
        step();
        lut_we = 1'b0;
    endtask

    task automatic start_at(input logic [9:0] a);
        start = 1'b1; start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({instr_valid, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags valid/done=%b required 00", {instr_valid, done});
        end
        checks++;
        if (instr_pc !== 10'h000) begin
            errors++; $display("FAIL reset_pc got %h required 000", instr_pc);
        end
        $display("test_reset done");
    endtask

    task automatic test_start;
        do_reset();
        lut_write(4'd3, 10'h080);
        start = 1'b1; start_addr = 10'h010;
        #1;
        checks++;
        if (imem_addr !== 10'h010) begin
            errors++; $display("FAIL start_addr got %h required 010", imem_addr);
        end
        step();
        start = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h010) begin
            errors++; $display("FAIL start_first valid=%b pc=%h required 1 010", instr_valid, instr_pc);
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'(10'h010 + i)) begin
                errors++; $display("FAIL seq_%0d valid=%b pc=%h required 1 %h", i, instr_valid, instr_pc, 10'(10'h010 + i));
            end
        end
        $display("test_start done");
    endtask

    task automatic test_jump;
        step();
        step();
        checks++;
        if (instr_pc !== 10'h014 || opcode !== 5'b11001 || operand !== 4'd3) begin
            errors++; $display("FAIL jump_decode pc=%h op=%b opd=%0d required 014 11001 3", instr_pc, opcode, operand);
        end
        checks++;
        if (imem_addr !== 10'h080) begin
            errors++; $display("FAIL jump_addr got %h required 080", imem_addr);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h080) begin
            errors++; $display("FAIL jump_target valid=%b pc=%h required 1 080", instr_valid, instr_pc);
        end
        $display("test_jump done");
    endtask

    task automatic test_branch;
        do_reset();
        lut_write(4'd3, 10'h080);
        branch_taken = 1'b0;
        start_at(10'h050);
        step();
        checks++;
        if (instr_pc !== 10'h051) begin
            errors++; $display("FAIL branch_not_taken pc=%h required 051", instr_pc);
        end
        do_reset();
        lut_write(4'd3, 10'h080);
        branch_taken = 1'b1;
        start_at(10'h050);
        #1;
        checks++;
        if (imem_addr !== 10'h080) begin
            errors++; $display("FAIL branch_taken_addr got %h required 080", imem_addr);
        end
        step();
        branch_taken = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h080) begin
            errors++; $display("FAIL branch_taken_pc valid=%b pc=%h required 1 080", instr_valid, instr_pc);
        end
        $display("test_branch done");
    endtask

    task automatic test_stall;
        do_reset();
        lut_write(4'd3, 10'h080);
        start_at(10'h020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_addr !== 10'h020) begin
                errors++; $display("FAIL stall_addr_%0d got %h required 020", i, imem_addr);
            end
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'h020 || instr !== 9'h193) begin
                errors++; $display("FAIL stall_hold_%0d valid=%b pc=%h instr=%h required 1 020 193", i, instr_valid, instr_pc, instr);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 10'h080) begin
            errors++; $display("FAIL stall_release_addr got %h required 080", imem_addr);
        end
        step();
        checks++;
        if (instr_pc !== 10'h080) begin
            errors++; $display("FAIL stall_release_pc got %h required 080", instr_pc);
        end
        $display("test_stall done");
    endtask

    task automatic test_wrap;
        do_reset();
        start_at(10'h3FF);
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h000) begin
            errors++; $display("FAIL wrap valid=%b pc=%h required 1 000", instr_valid, instr_pc);
        end
        $display("test_wrap done");
    endtask

    task automatic test_halt;
        do_reset();
        start_at(10'h030);
        checks++;
        if (instr_valid !== 1'b1 || done !== 1'b0 || instr !== 9'h1FF) begin
            errors++; $display("FAIL halt_present valid=%b done=%b instr=%h required 1 0 1ff", instr_valid, done, instr);
        end
        step();
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 10'h031) begin
            errors++; $display("FAIL halt_done done=%b valid=%b addr=%h required 1 0 031", done, instr_valid, imem_addr);
        end
        step();
        checks++;
        if (done !== 1'b1 || imem_addr !== 10'h031) begin
            errors++; $display("FAIL halt_frozen done=%b addr=%h required 1 031", done, imem_addr);
        end
        start_at(10'h040);
        checks++;
        if (done !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 10'h040) begin
            errors++; $display("FAIL halt_restart done=%b valid=%b pc=%h required 0 1 040", done, instr_valid, instr_pc);
        end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid;
        do_reset();
        lut_write(4'd3, 10'h080);
        start_at(10'h010);
        step();
        reset = 1'b1; start = 1'b1; start_addr = 10'h050;
        step();
        reset = 1'b0; start = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || done !== 1'b0 || instr_pc !== 10'h000) begin
            errors++; $display("FAIL mid_reset valid=%b done=%b pc=%h required 0 0 000", instr_valid, done, instr_pc);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'h000) begin
            errors++; $display("FAIL mid_reset_idle valid=%b addr=%h required 0 000", instr_valid, imem_addr);
        end
        start_at(10'h014);
        checks++;
        if (imem_addr !== 10'h000) begin
            errors++; $display("FAIL lut_cleared target=%h required 000", imem_addr);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_lut_same_cycle;
        do_reset();
        lut_write(4'd5, 10'h0A0);
        start_at(10'h060);
        lut_we = 1'b1; lut_idx = 4'd5; lut_data = 10'h0C0;
        #1;
        checks++;
        if (imem_addr !== 10'h0A0) begin
            errors++; $display("FAIL lut_old_value got %h required 0a0", imem_addr);
        end
        step();
        lut_we = 1'b0;
        checks++;
        if (instr_pc !== 10'h0A0) begin
            errors++; $display("FAIL lut_old_pc got %h required 0a0", instr_pc);
        end
        do_reset();
        lut_write(4'd5, 10'h0C0);
        start_at(10'h060);
        checks++;
        if (imem_addr !== 10'h0C0) begin
            errors++; $display("FAIL lut_new_value got %h required 0c0", imem_addr);
        end
        $display("test_lut_same_cycle done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[10'h014] = 9'h193;
        rom[10'h020] = 9'h193;
        rom[10'h030] = 9'h1FF;
        rom[10'h050] = 9'h183;
        rom[10'h060] = 9'h195;
        reset = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
        branch_taken = 1'b0; lut_we = 1'b0; lut_idx = '0; lut_data = '0;
        step();
        test_reset();
        test_start();
        test_jump();
        test_branch();
        test_stall();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_lut_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
